freq_meter: RTL and testbench

Gated frequency meter: counts rising edges of an external, asynchronous signal over a fixed window of `clk` cycles and presents each window's count through a valid/ready handshake. It is the measuring end of the phase-accumulator pulse generator. Loop its output back into `sig_in` to check the programmed rate, or use it standalone to measure board inputs.

---
 rtl/freq_meter.sv | 168 ++++++++++++++++
 tb/tb_freq_meter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clk cycles.
// Define FREQ_METER_AVG_EN to report a 4-window running average instead of raw window counts.
module freq_meter #(
    parameter int GATE_CYCLES = 100000,
    parameter int CNT_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 count_valid,
    input  logic                 count_ready,
    output logic                 count_ovf,
    output logic                 overrun
);
    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   delayed_reg;
    logic                   edge_pulse;
    logic [GATE_W-1:0]      gate_reg;
    logic [CNT_WIDTH-1:0]   edge_cnt_reg, edge_final;
    logic                   win_ovf_reg, ovf_final;
    logic                   measuring, window_close;
    logic [CNT_WIDTH-1:0]   result_val;
    logic                   result_ovf, result_load;
    logic [CNT_WIDTH-1:0]   count_out_reg;
    logic                   count_valid_reg, count_ovf_reg, overrun_reg;

    // Synchronizer chain for the asynchronous input
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst)
                    sync_reg[gi] <= 1'b0;
                else if (gi == 0)
                    sync_reg[gi] <= sig_in;
                else
                    sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            delayed_reg <= 1'b0;
        else
            delayed_reg <= sync_reg[SYNC_STAGES-1];
    end

    assign edge_pulse = sync_reg[SYNC_STAGES-1] & ~delayed_reg;

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable)  state_next = MEASURE;
            MEASURE: if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A window only closes while still enabled; a falling enable discards it
    assign measuring    = (state_reg == MEASURE) && enable;
    assign window_close = measuring && (gate_reg == GATE_LAST);

    // Saturating edge count including the pulse of the current cycle
    always_comb begin
        edge_final = edge_cnt_reg;
        ovf_final  = win_ovf_reg;
        if (edge_pulse) begin
            if (&edge_cnt_reg)
                ovf_final = 1'b1;
            else
                edge_final = edge_cnt_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !measuring || window_close) begin
            gate_reg     <= '0;
            edge_cnt_reg <= '0;
            win_ovf_reg  <= 1'b0;
        end else begin
            gate_reg     <= gate_reg + GATE_W'(1);
            edge_cnt_reg <= edge_final;
            win_ovf_reg  <= ovf_final;
        end
    end

`ifdef FREQ_METER_AVG_EN
    logic [CNT_WIDTH-1:0] hist_reg [4];
    logic [3:0]           flag_reg;
    logic [2:0]           fill_reg;
    logic [CNT_WIDTH+1:0] sum_reg, sum_next;
    logic                 hist_clear;

    assign hist_clear = rst || !measuring;
    // Running sum: add the newest window, drop the one falling out of the history
    assign sum_next    = sum_reg + {2'b00, edge_final} - {2'b00, hist_reg[3]};
    assign result_val  = sum_next[CNT_WIDTH+1:2];
    assign result_ovf  = ovf_final | flag_reg[0] | flag_reg[1] | flag_reg[2];
    assign result_load = window_close && (fill_reg >= 3'd3);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hist
            always_ff @(posedge clk) begin
                if (hist_clear) begin
                    hist_reg[gi] <= '0;
                    flag_reg[gi] <= 1'b0;
                end else if (window_close) begin
                    hist_reg[gi] <= (gi == 0) ? edge_final : hist_reg[(gi > 0) ? gi - 1 : 0];
                    flag_reg[gi] <= (gi == 0) ? ovf_final  : flag_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (hist_clear) begin
            sum_reg  <= '0;
            fill_reg <= '0;
        end else if (window_close) begin
            sum_reg  <= sum_next;
            fill_reg <= (fill_reg == 3'd4) ? 3'd4 : fill_reg + 3'd1;
        end
    end
`else
    assign result_val  = edge_final;
    assign result_ovf  = ovf_final;
    assign result_load = window_close;
`endif

    // Result register and valid/ready handshake; a close with a pending unaccepted result is an overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out_reg   <= '0;
            count_valid_reg <= 1'b0;
            count_ovf_reg   <= 1'b0;
            overrun_reg     <= 1'b0;
        end else if (result_load) begin
            count_out_reg   <= result_val;
            count_ovf_reg   <= result_ovf;
            count_valid_reg <= 1'b1;
            if (count_valid_reg && !count_ready)
                overrun_reg <= 1'b1;
        end else if (count_valid_reg && count_ready) begin
            count_valid_reg <= 1'b0;
        end
    end

    assign count_out   = count_out_reg;
    assign count_valid = count_valid_reg;
    assign count_ovf   = count_ovf_reg;
    assign overrun     = overrun_reg;
endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter: two instances (8-bit and saturating 3-bit counters) against a
// window-level reference model built from sampled input history.
module tb_freq_meter;
    localparam int G    = 100;
    localparam int S    = 2;
    localparam int NCYC = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       sig_in = 1'b0;
    logic       count_ready = 1'b0;
    logic [7:0] cnt_a;
    logic [2:0] cnt_b;
    logic       valid_a, valid_b, ovf_a, ovf_b, ovr_a, ovr_b;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(G), .CNT_WIDTH(8), .SYNC_STAGES(S)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
        .count_out(cnt_a), .count_valid(valid_a), .count_ready(count_ready),
        .count_ovf(ovf_a), .overrun(ovr_a));

    freq_meter #(.GATE_CYCLES(G), .CNT_WIDTH(3), .SYNC_STAGES(S)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
        .count_out(cnt_b), .count_valid(valid_b), .count_ready(count_ready),
        .count_ovf(ovf_b), .overrun(ovr_b));

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    bit sig_hist [NCYC];
    int cyc      = 0;
    int last_rst = -1000;
    bit m_meas   = 1'b0;
    int wstart   = 0;
    bit m_valid  = 1'b0;
    bit m_ovr    = 1'b0;
    int m_cnt [2];
    int m_ovf [2];
    int maxv  [2] = '{255, 7};
    int mh    [2][4];
    int mf    [2][4];
    int m_fill = 0;

    function automatic bit sv(int k);
        if (k <= last_rst || k < 0) return 1'b0;
        return sig_hist[k];
    endfunction

    // Edges whose pulse is counted at clock edges (a, b]
    function automatic int pulses(int a, int b);
        int n = 0;
        for (int t = a + 1; t <= b; t++)
            if (sv(t - S) && !sv(t - S - 1)) n++;
        return n;
    endfunction

    bit r_in, e_in, rd_in, s_in, closing, produce;
    int n_edges;
    int new_cnt [2];
    int new_ovf [2];

    always @(posedge clk) begin
        r_in = rst; e_in = enable; rd_in = count_ready; s_in = sig_in;
        if (cyc < NCYC) sig_hist[cyc] = s_in;
        if (r_in) begin
            last_rst = cyc; m_meas = 0; m_valid = 0; m_ovr = 0; m_fill = 0;
            for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
        end else begin
            closing = 0; produce = 0;
            if (!m_meas) begin
                if (e_in) begin m_meas = 1; wstart = cyc; end
            end else if (!e_in) begin
                m_meas = 0; m_fill = 0;
            end else if (cyc - wstart == G) begin
                closing = 1;
                n_edges = pulses(wstart, cyc);
                wstart = cyc;
            end
            if (closing) begin
                for (int i = 0; i < 2; i++) begin
`ifdef FREQ_METER_AVG_EN
                    int sum = 0;
                    int orf = 0;
                    for (int j = 3; j > 0; j--) begin mh[i][j] = mh[i][j-1]; mf[i][j] = mf[i][j-1]; end
                    mh[i][0] = (n_edges > maxv[i]) ? maxv[i] : n_edges;
                    mf[i][0] = (n_edges > maxv[i]) ? 1 : 0;
                    for (int j = 0; j < 4; j++) begin sum += mh[i][j]; orf |= mf[i][j]; end
                    new_cnt[i] = sum / 4;
                    new_ovf[i] = orf;
`else
                    new_cnt[i] = (n_edges > maxv[i]) ? maxv[i] : n_edges;
                    new_ovf[i] = (n_edges > maxv[i]) ? 1 : 0;
`endif
                end
`ifdef FREQ_METER_AVG_EN
                if (m_fill < 4) m_fill++;
                produce = (m_fill == 4);
`else
                produce = 1;
`endif
            end
            if (m_valid && rd_in)
                $display("accept cyc=%0d count_a=%0d ovf_a=%0d count_b=%0d ovf_b=%0d",
                         cyc, m_cnt[0], m_ovf[0], m_cnt[1], m_ovf[1]);
            if (produce) begin
                if (m_valid && !rd_in) m_ovr = 1;
                m_valid = 1;
                for (int i = 0; i < 2; i++) begin m_cnt[i] = new_cnt[i]; m_ovf[i] = new_ovf[i]; end
            end else if (m_valid && rd_in) begin
                m_valid = 0;
            end
        end
        #1;
        check("valid_a",   64'(valid_a), 64'(m_valid));
        check("valid_b",   64'(valid_b), 64'(m_valid));
        check("overrun_a", 64'(ovr_a),   64'(m_ovr));
        check("overrun_b", 64'(ovr_b),   64'(m_ovr));
        check("count_a",   64'(cnt_a),   64'(m_cnt[0]));
        check("count_b",   64'(cnt_b),   64'(m_cnt[1]));
        check("ovf_a",     64'(ovf_a),   64'(m_ovf[0]));
        check("ovf_b",     64'(ovf_b),   64'(m_ovf[1]));
        cyc++;
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        rst = 0;

        // Basic count: 10-clk square wave
        count_ready = 1; enable = 1;
        for (int i = 0; i < 350; i++) begin
            @(negedge clk);
            sig_in = ((i % 10) < 5);
        end
        enable = 0; sig_in = 0;
        repeat (10) @(negedge clk);

        // Boundary: edge pulse lands exactly at gate count G-1
        enable = 1;
        repeat (98) @(negedge clk);
        sig_in = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (valid_a) seen = 1;
        end
`ifndef FREQ_METER_AVG_EN
        check("boundary_seen", 64'(seen), 64'd1);
        check("boundary_count", 64'(cnt_a), 64'd1);
`endif
        repeat (110) @(negedge clk);
        enable = 0; sig_in = 0;
        repeat (10) @(negedge clk);

        // Saturation: edge every 2 clks
        enable = 1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            sig_in = i[0];
        end
        enable = 0; sig_in = 0;
        repeat (10) @(negedge clk);

        // Overrun: no consumer across two closes
        count_ready = 0; enable = 1;
        for (int i = 0; i < 205; i++) begin
            @(negedge clk);
            sig_in = 1'($urandom_range(1));
        end
`ifndef FREQ_METER_AVG_EN
        check("overrun_valid", 64'(valid_a), 64'd1);
        check("overrun_flag", 64'(ovr_a), 64'd1);
`endif
        count_ready = 1;
        @(negedge clk);
        enable = 0;
        @(negedge clk);
`ifndef FREQ_METER_AVG_EN
        check("overrun_drain", 64'(valid_a), 64'd0);
        check("overrun_sticky", 64'(ovr_a), 64'd1);
`endif
        repeat (10) @(negedge clk);

        // Abort at gate count 50, then full window after re-enable
        enable = 1;
        repeat (50) @(negedge clk);
        enable = 0;
        repeat (150) @(negedge clk);
        check("abort_no_valid", 64'(valid_a), 64'd0);
        enable = 1;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            sig_in = ((i % 6) < 3);
        end

        // Reset mid-window
        repeat (40) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rst_count", 64'(cnt_a), 64'd0);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_overrun", 64'(ovr_a), 64'd0);
        rst = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            sig_in = 1'($urandom_range(1));
            count_ready = ($urandom_range(3) != 0);
            if (enable) begin
                if ($urandom_range(299) == 0) enable = 0;
            end else if ($urandom_range(19) == 0) begin
                enable = 1;
            end
        end
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
